dsc_mul_n: RTL and testbench

Parametrised deterministic stochastic-computing (DSC) multiplier. It computes the exact product of `NUM_INPUTS` unsigned operands, each `WIDTH` bits wide, using the serial clock-division scheme. Each operand drives a counter/comparator stochastic number generator. Counter k advances only when counters 0..k-1 wrap together, the generator bits are ANDed, and an output counter accumulates the ones. It succeeds the fixed 4×10-bit multiplier and adds a start/ready/done handshake, operand latching, an enable stall and an optional zero-operand early exit.

---
 rtl/dsc_pkg.sv | 20 ++
 rtl/dsc_sng.sv | 29 ++
 rtl/dsc_mul_n.sv | 115 +++++++++++
 tb/tb_dsc_mul_n.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/dsc_pkg.sv
// dsc_pkg: shared types and sizing helpers for the DSC multiplier.
package dsc_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } dsc_state_e;

  // Sizing for the default build (4 operands x 10 bits)
  localparam int          DEF_NUM_INPUTS = 4;
  localparam int          DEF_WIDTH      = 10;
  localparam int          Z_W            = DEF_NUM_INPUTS * DEF_WIDTH;
  localparam longint unsigned RUN_CYCLES = 64'd1 << Z_W;

  // Product width for an arbitrary configuration
  function automatic int z_width(input int n, input int w);
    return n * w;
  endfunction

endpackage

// File: rtl/dsc_sng.sv
// dsc_sng: one stochastic number generator lane -- a WIDTH-bit counter
// compared against a latched operand. sn is 1 while op > ctr, so over a
// full counter sweep it produces exactly op ones.
module dsc_sng
  import dsc_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [WIDTH-1:0] op,
  output logic             sn,
  output logic             at_max
);

  logic [WIDTH-1:0] r_ctr;

  // Lane counter: cleared on reset or new operation, wraps naturally
  always_ff @(posedge clk) begin
    if (rst || clr) r_ctr <= '0;
    else if (inc)   r_ctr <= r_ctr + 1'b1;
  end

  assign sn     = (op > r_ctr);
  assign at_max = &r_ctr;

endmodule

// File: rtl/dsc_mul_n.sv
// dsc_mul_n: deterministic stochastic-computing multiplier of NUM_INPUTS
// unsigned WIDTH-bit operands using clock-division counter chaining.
// Optional macro DSC_ZERO_SKIP_EN: a start with any zero operand finishes
// in one cycle with z = 0 instead of sweeping the whole counter space.
module dsc_mul_n
  import dsc_pkg::*;
#(
  parameter int NUM_INPUTS = 4,
  parameter int WIDTH      = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        start,
  input  logic [NUM_INPUTS*WIDTH-1:0] ops,
  output logic                        ready,
  output logic                        busy,
  output logic [NUM_INPUTS*WIDTH-1:0] z,
  output logic                        done
);

  localparam int ZW = z_width(NUM_INPUTS, WIDTH);

  dsc_state_e              r_state, w_state_nxt;
  logic [ZW-1:0]           r_ops;
  logic [ZW-1:0]           r_acc;
  logic [ZW-1:0]           r_z;
  logic                    r_done;

  logic [NUM_INPUTS-1:0]   w_sn;
  logic [NUM_INPUTS-1:0]   w_at_max;
  logic [NUM_INPUTS:0]     w_chain;   // w_chain[k] = en & busy & all lower lanes at max
  logic                    w_accept;
  logic                    w_last;
  logic                    w_and;
  logic                    w_skip;
  logic [ZW-1:0]           w_and_ext;

  assign busy     = (r_state == ST_RUN);
  assign ready    = (r_state == ST_IDLE);
  assign w_accept = ready & start;
  assign w_chain[0] = en & busy;
  assign w_last   = w_chain[NUM_INPUTS];
  assign w_and    = &w_sn;
  assign w_and_ext = {{(ZW-1){1'b0}}, w_and};

`ifdef DSC_ZERO_SKIP_EN
  logic [NUM_INPUTS-1:0] w_op_zero;
  for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_zero
    assign w_op_zero[k] = (ops[k*WIDTH +: WIDTH] == '0);
  end
  assign w_skip = |w_op_zero;
`else
  assign w_skip = 1'b0;
`endif

  // Counter chain: lane k steps only when all lower lanes wrap together
  for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_lane
    assign w_chain[k+1] = w_chain[k] & w_at_max[k];
    dsc_sng #(.WIDTH(WIDTH)) u_sng (
      .clk    (clk),
      .rst    (rst),
      .clr    (w_accept),
      .inc    (w_chain[k]),
      .op     (r_ops[k*WIDTH +: WIDTH]),
      .sn     (w_sn[k]),
      .at_max (w_at_max[k])
    );
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state: leave IDLE on an accepted start, return after the last sweep cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start && !w_skip) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last)           w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: operand latch, ones accumulator, registered result and done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ops  <= '0;
      r_acc  <= '0;
      r_z    <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_ops <= ops;
        r_acc <= '0;
        if (w_skip) begin
          r_z    <= '0;
          r_done <= 1'b1;
        end
      end else if (w_last) begin
        r_z    <= r_acc + w_and_ext;
        r_done <= 1'b1;
      end else if (w_chain[0]) begin
        r_acc <= r_acc + w_and_ext;
      end
    end
  end

  assign z    = r_z;
  assign done = r_done;

endmodule

// File: tb/tb_dsc_mul_n.sv
// tb_dsc_mul_n: directed-vector bench for three configurations of dsc_mul_n.
// A: 2x3 bits, B: 3x2 bits (enable stall), C: 4x3 bits (long sweep, zero operand).
module tb_dsc_mul_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A : 2 x 3
  logic       rst_a, en_a, start_a, ready_a, busy_a, done_a;
  logic [5:0] ops_a, z_a;
  // DUT B : 3 x 2
  logic       rst_b, en_b, start_b, ready_b, busy_b, done_b;
  logic [5:0] ops_b, z_b;
  // DUT C : 4 x 3
  logic        rst_c, en_c, start_c, ready_c, busy_c, done_c;
  logic [11:0] ops_c, z_c;

  dsc_mul_n #(.NUM_INPUTS(2), .WIDTH(3)) u_a (
    .clk(clk), .rst(rst_a), .en(en_a), .start(start_a), .ops(ops_a),
    .ready(ready_a), .busy(busy_a), .z(z_a), .done(done_a));
  dsc_mul_n #(.NUM_INPUTS(3), .WIDTH(2)) u_b (
    .clk(clk), .rst(rst_b), .en(en_b), .start(start_b), .ops(ops_b),
    .ready(ready_b), .busy(busy_b), .z(z_b), .done(done_b));
  dsc_mul_n #(.NUM_INPUTS(4), .WIDTH(3)) u_c (
    .clk(clk), .rst(rst_c), .en(en_c), .start(start_c), .ops(ops_c),
    .ready(ready_c), .busy(busy_c), .z(z_c), .done(done_c));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic done_of(input int sel);
    case (sel)
      0:       return done_a;
      1:       return done_b;
      default: return done_c;
    endcase
  endfunction

  function automatic logic [63:0] z_of(input int sel);
    case (sel)
      0:       return 64'(z_a);
      1:       return 64'(z_b);
      default: return 64'(z_c);
    endcase
  endfunction

  // Present start for one edge (E0); returns at E0 + #1
  task automatic go(input int sel, input logic [11:0] ops);
    case (sel)
      0:       begin start_a = 1'b1; ops_a = ops[5:0]; end
      1:       begin start_b = 1'b1; ops_b = ops[5:0]; end
      default: begin start_c = 1'b1; ops_c = ops;      end
    endcase
    step();
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
  endtask

  // Count edges until done is seen; bounded by limit
  task automatic wait_done(input int sel, input int limit, output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!done_of(sel) && cyc < limit);
  endtask

  int  cyc, pre;
  logic seen;

  initial begin
    rst_a = 1; rst_b = 1; rst_c = 1;
    en_a = 1; en_b = 1; en_c = 1;
    start_a = 0; start_b = 0; start_c = 0;
    ops_a = '0; ops_b = '0; ops_c = '0;
    repeat (2) step();
    chk("rst_ready", ready_a, 1);
    chk("rst_busy",  busy_a,  0);
    chk("rst_done",  done_a,  0);
    chk("rst_z",     z_a,     0);
    rst_a = 0; rst_b = 0; rst_c = 0;
    step();

    // A: 6 * 5
    go(0, {6'd0, 3'd6, 3'd5});
    chk("a_busy", busy_a, 1);
    chk("a_ready_run", ready_a, 0);
    wait_done(0, 120, cyc);
    chk("a65_lat", cyc, 64);
    chk("a65_z", z_a, 30);
    chk("a65_ready_done", ready_a, 1);
    step();
    chk("a65_done_pulse", done_a, 0);
    chk("a65_z_hold", z_a, 30);

    // A: start and ops changes during RUN are ignored
    go(0, {6'd0, 3'd3, 3'd5});
    repeat (9) step();
    start_a = 1; ops_a = {3'd7, 3'd7};
    step();
    start_a = 0; ops_a = {3'd1, 3'd2};
    chk("ign_busy", busy_a, 1);
    wait_done(0, 120, cyc);
    chk("ign_lat", cyc + 10, 64);
    chk("ign_z", z_a, 15);

    // A: reset 20 cycles into a run
    go(0, {6'd0, 3'd7, 3'd7});
    repeat (19) step();
    rst_a = 1;
    step();
    rst_a = 0;
    chk("mrst_ready", ready_a, 1);
    chk("mrst_busy", busy_a, 0);
    chk("mrst_z", z_a, 0);
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      if (done_a) seen = 1;
      step();
    end
    chk("mrst_nodone", seen, 0);
    go(0, {6'd0, 3'd7, 3'd7});
    wait_done(0, 120, cyc);
    chk("mrst_new_lat", cyc, 64);
    chk("mrst_new_z", z_a, 49);

    // A: back-to-back, second start in the done cycle
    step();
    go(0, {6'd0, 3'd4, 3'd4});
    wait_done(0, 120, cyc);
    chk("b2b1_lat", cyc, 64);
    chk("b2b1_z", z_a, 16);
    go(0, {6'd0, 3'd1, 3'd1});
    chk("b2b_busy", busy_a, 1);
    wait_done(0, 120, cyc);
    chk("b2b2_lat", cyc, 64);
    chk("b2b2_z", z_a, 1);

    // B: 3 * 2 * 1 with a 10-cycle enable stall
    go(1, {6'd0, 2'd3, 2'd2, 2'd1});
    repeat (20) step();
    en_b = 0;
    repeat (10) step();
    chk("stall_busy", busy_b, 1);
    en_b = 1;
    wait_done(1, 120, pre);
    chk("stall_lat", pre + 30, 74);
    chk("stall_z", z_of(1), 6);

    // C: 7^4
    go(2, {3'd7, 3'd7, 3'd7, 3'd7});
    wait_done(2, 4200, cyc);
    chk("c7_lat", cyc, 4096);
    chk("c7_z", z_of(2), 2401);
    step();

    // C: a zero operand
    go(2, {3'd0, 3'd7, 3'd7, 3'd7});
`ifdef DSC_ZERO_SKIP_EN
    chk("zs_done", done_c, 1);
    chk("zs_busy", busy_c, 0);
    chk("zs_z", z_of(2), 0);
    step();
    chk("zs_pulse", done_c, 0);
`else
    chk("z0_busy", busy_c, 1);
    wait_done(2, 4200, cyc);
    chk("z0_lat", cyc, 4096);
    chk("z0_z", z_of(2), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
